cdc_100_125_arb: RTL and testbench

- Round-robin arbiter in the 100 MHz domain that shares one 100→125 MHz synchronous crossing between NCH requesters.
- Each requester has a valid/ready interface. The block grants one requester at a time, in bursts of up to MAXBURST beats.
- Its output is the crossing's data input and valid, with the channel index packed into the upper data bits.
- The crossing accepts 100% enable on its input, so the block applies no backpressure beyond its own `en` input.

---
 rtl/cdc_100_125_arb_if.sv | 18 +
 rtl/cdc_100_125_arb.sv | 141 ++++++++++++++
 tb/tb_cdc_100_125_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cdc_100_125_arb_if.sv
// Request bus of the 100->125 MHz crossing arbiter.
// The master side is the set of requesters plus whatever observes the crossing
// input; the slave side is the arbiter itself.
interface cdc_100_125_arb_if #(
    parameter int NB  = 8,
    parameter int NCH = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH*NB-1:0] req_data;   // channel k at [k*NB +: NB]
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NB+CW-1:0]  o;          // {channel, payload} to the crossing
    logic              ov;         // crossing valid

    modport master (output req_data, req_valid, input  req_ready, o, ov);
    modport slave  (input  req_data, req_valid, output req_ready, o, ov);
endinterface

// File: rtl/cdc_100_125_arb.sv
// Round-robin arbiter sharing one 100->125 MHz crossing between NCH requesters.
// Grants one channel at a time for bursts of up to MAXBURST beats; one idle
// arbitration cycle separates grants. The output beat is registered and tagged
// with the channel index in its upper bits.
// Optional: define CDC_ARB_PRIO_EN to give channel 0 strict priority (it wins
// every arbitration and cuts short any other channel's burst).
module cdc_100_125_arb #(
    parameter int NB       = 8,
    parameter int NCH      = 4,
    parameter int MAXBURST = 4
) (
    input  logic              c100,
    input  logic              rst_n,
    input  logic              en,
    cdc_100_125_arb_if.slave  bus
);
    localparam int CW = $clog2(NCH);
    localparam int KW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [KW-1:0] CNT_MAX  = KW'(MAXBURST - 1);
    localparam logic [CW-1:0] LAST_RST = CW'(NCH - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_grant, w_grant_nxt;
    logic [CW-1:0]    r_last,  w_last_nxt;
    logic [KW-1:0]    r_count, w_count_nxt;
    logic [NB+CW-1:0] r_o;
    logic             r_ov;
    logic [NCH-1:0]   w_ready;
    logic             w_xfer;
    logic [NB-1:0]    w_data;
    logic [CW-1:0]    w_pick;

    // First valid channel after l, wrapping past NCH-1 back to 0.
    function automatic logic [CW-1:0] f_rr_pick(input logic [NCH-1:0] v,
                                                input logic [CW-1:0]  l);
        logic [CW-1:0] pick;
        logic [CW-1:0] sel;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(l) + i) % NCH;
            sel = CW'(idx);
            if (!found && v[sel]) begin
                pick  = sel;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Ready depends only on registered grant state and en, never on valid.
    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_ready[k] = (r_state == GRANT) && en && (r_grant == CW'(k));
            if (r_grant == CW'(k)) w_data = bus.req_data[k*NB +: NB];
        end
        w_xfer = |(w_ready & bus.req_valid);
`ifdef CDC_ARB_PRIO_EN
        w_pick = bus.req_valid[0] ? '0 : f_rr_pick(bus.req_valid, r_last);
`else
        w_pick = f_rr_pick(bus.req_valid, r_last);
`endif
    end

    // Next-state: arbitrate in IDLE, count beats and detect grant end in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (en && |bus.req_valid) begin
                    w_grant_nxt = w_pick;
                    w_count_nxt = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                // en low freezes everything: a pause is neither a beat nor an end.
                if (en) begin
                    if (!w_xfer) begin
                        w_last_nxt  = r_grant;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end else if (r_count == CNT_MAX) begin
                        w_last_nxt  = r_grant;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
`ifdef CDC_ARB_PRIO_EN
                    end else if ((r_grant != '0) && bus.req_valid[0]) begin
                        // current beat still goes; channel 0 takes the next grant
                        w_last_nxt  = r_grant;
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_count_nxt = r_count + KW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge c100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Output beat to the crossing; o holds between transfers.
    always_ff @(posedge c100 or negedge rst_n) begin
        if (!rst_n) begin
            r_ov <= 1'b0;
            r_o  <= '0;
        end else begin
            r_ov <= w_xfer;
            if (w_xfer) r_o <= {r_grant, w_data};
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.o         = r_o;
    assign bus.ov        = r_ov;
endmodule

// File: tb/tb_cdc_100_125_arb.sv
// Directed bench for cdc_100_125_arb (NCH=4, MAXBURST=4, NB=8).
// Expected beats are queued when stimulus is set up and popped by a monitor
// whenever ov is seen.
module tb_cdc_100_125_arb;
    localparam int NB = 8, NCH = 4, MAXBURST = 4, CW = 2;

    logic c100 = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 c100 = ~c100;

    cdc_100_125_arb_if #(.NB(NB), .NCH(NCH)) bus();

    cdc_100_125_arb #(.NB(NB), .NCH(NCH), .MAXBURST(MAXBURST)) dut (
        .c100  (c100),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    // Per-channel source: offers rem beats with data base+sent.
    int rem[NCH];
    int sent[NCH];
    int base[NCH];
    logic [NCH-1:0]    hs;
    logic [NCH*NB-1:0] drv_data;
    logic [NCH-1:0]    drv_valid;

    always_comb begin
        drv_data  = '0;
        drv_valid = '0;
        for (int k = 0; k < NCH; k++) begin
            drv_data[k*NB +: NB] = NB'(base[k] + sent[k]);
            drv_valid[k]         = (rem[k] != 0);
        end
    end
    assign bus.req_data  = drv_data;
    assign bus.req_valid = drv_valid;

    // Handshake seen mid-cycle completes on the next rising edge.
    always @(negedge c100) hs = bus.req_valid & bus.req_ready;
    always @(posedge c100) begin
        #1;
        for (int k = 0; k < NCH; k++)
            if (hs[k]) begin
                sent[k]++;
                if (rem[k] > 0) rem[k]--;
            end
    end

    logic [NB+CW-1:0] exp_q[$];
    int  nchk = 0, nfail = 0;
    bit  mon_off = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int tag, input int d);
        exp_q.push_back({CW'(tag), NB'(d)});
    endtask

    // Scoreboard monitor.
    always @(negedge c100) begin
        if (!mon_off && bus.ov === 1'b1) begin
            if (exp_q.size() == 0) check("extra_beat", 32'(bus.o), 32'hFFFF_FFFF);
            else                   check("beat", 32'(bus.o), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_sent(input int k, input int n, input string tag);
        int i = 0;
        while (sent[k] < n && i < 40) begin
            @(posedge c100); #2;
            i++;
        end
        check(tag, 32'(sent[k]), 32'(n));
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(negedge c100);
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge c100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        int n;
        for (int k = 0; k < NCH; k++) begin rem[k] = 0; sent[k] = 0; base[k] = 0; end
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge c100);
        #2 rst_n = 1'b1;

        // 1: idle after reset
        repeat (10) begin
            @(negedge c100);
            check("t1_ov", 32'(bus.ov), 32'd0);
            check("t1_o", 32'(bus.o), 32'd0);
            check("t1_ready", 32'(bus.req_ready), 32'd0);
        end

        // 2: single channel, two bursts separated by one arbitration cycle
        for (int i = 0; i < 8; i++) push(2, 'h10 + i);
        @(posedge c100); #2;
        base[2] = 'h10; sent[2] = 0; rem[2] = 8;
        n = 0;
        @(negedge c100);
        while (bus.ov !== 1'b1 && n < 20) begin @(negedge c100); n++; end
        pat = 9'(bus.ov);
        repeat (8) begin @(negedge c100); pat = {pat[7:0], bus.ov}; end
        check("t2_ov_pattern", 32'(pat), 32'b1_1110_1111);
        wait_drain("t2_drain");

        // asynchronous reset mid-burst, between clock edges
        mon_off = 1'b1;
        @(posedge c100); #2;
        sent[2] = 0; rem[2] = 100;
        n = 0;
        @(negedge c100);
        while (!(bus.ov === 1'b1 && bus.req_ready[2] === 1'b1) && n < 20) begin
            @(negedge c100); n++;
        end
        check("rst_pre_ov", 32'(bus.ov), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ov", 32'(bus.ov), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_o", 32'(bus.o), 32'd0);
        for (int k = 0; k < NCH; k++) rem[k] = 0;
        repeat (2) @(posedge c100);
        #2;
        for (int k = 0; k < NCH; k++) sent[k] = 0;
        exp_q.delete();

        // 3: all channels busy; arbitration restarts at channel 0
        for (int i = 0; i < 4; i++) push(0, 'h40 + i);
        for (int r = 0; r < 2; r++)
            for (int k = 1; k < NCH; k++)
                for (int i = 0; i < 4; i++) push(k, 'h40 + 'h10 * k + 4 * r + i);
        for (int k = 0; k < NCH; k++) base[k] = 'h40 + 'h10 * k;
        rem[0] = 4; rem[1] = 8; rem[2] = 8; rem[3] = 8;
        rst_n = 1'b1;
        mon_off = 1'b0;
        wait_drain("t3_drain");

        // 4: en pause after two beats of a burst on channel 1
        for (int i = 0; i < 4; i++) push(1, 'h80 + i);
        push(3, 'h90); push(3, 'h91);
        @(posedge c100); #2;
        base[1] = 'h80; sent[1] = 0; base[3] = 'h90; sent[3] = 0;
        rem[1] = 4; rem[3] = 2;
        wait_sent(1, 2, "t4_two_beats");
        en = 1'b0;
        @(negedge c100);
        check("t4_ready_pause0", 32'(bus.req_ready), 32'd0);
        repeat (2) begin
            @(negedge c100);
            check("t4_ov_pause", 32'(bus.ov), 32'd0);
            check("t4_ready_pause", 32'(bus.req_ready), 32'd0);
        end
        @(posedge c100); #2;
        check("t4_sent_held", 32'(sent[1]), 32'd2);
        en = 1'b1;
        wait_drain("t4_drain");

        // 5: single beat on 3, drain ends grant, search wraps to 0 before 2
        push(3, 'hA0); push(0, 'hB0); push(2, 'hC0);
        @(posedge c100); #2;
        base[3] = 'hA0; sent[3] = 0; rem[3] = 1;
        wait_sent(3, 1, "t5_ch3_beat");
        base[0] = 'hB0; sent[0] = 0; base[2] = 'hC0; sent[2] = 0;
        rem[0] = 1; rem[2] = 1;
        wait_drain("t5_drain");

        // 6: channel 0 request arrives during a channel 2 burst
`ifdef CDC_ARB_PRIO_EN
        push(2, 'hD0); push(2, 'hD1); push(0, 'hE0);
        push(2, 'hD2); push(2, 'hD3); push(3, 'hF0);
`else
        for (int i = 0; i < 4; i++) push(2, 'hD0 + i);
        push(3, 'hF0); push(0, 'hE0);
`endif
        @(posedge c100); #2;
        base[2] = 'hD0; sent[2] = 0; rem[2] = 4;
        wait_sent(2, 1, "t6_first_beat");
        base[0] = 'hE0; sent[0] = 0; base[3] = 'hF0; sent[3] = 0;
        rem[0] = 1; rem[3] = 1;
        wait_drain("t6_drain");
        check("t6_idle_ov", 32'(bus.ov), 32'd0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
